snitch_dma_event_monitor: RTL

// Passive tap on the cluster DMA's AXI master port and internal data buffer. Produces the
// per-cycle DMA event record (stalls, handshakes, burst len/size, bytes written, busy)

---
 rtl/snitch_dma_event_monitor.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/snitch_dma_event_monitor.sv
// snitch_dma_event_monitor
// Passive observer of the cluster DMA's AXI master port and its internal data
// buffer. Every cycle it emits a registered event record for the cluster
// performance counters. It never drives AXI.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   {aw,ar,w,r,b}_valid_i/_ready_i AXI channel handshakes (observed only)
//   aw_len_i/aw_size_i             AW burst attributes
//   ar_len_i/ar_size_i             AR burst attributes
//   w_strb_i                       W byte strobes
//   r_last_i                       last beat of an R burst
//   buf_{w,r}_valid_i/_ready_i     DMA data-buffer handshakes
//   {aw,ar,r,w}_stall_o            valid held without ready
//   buf_{w,r}_stall_o              buffer-side stalls
//   {aw,ar,r,w,b}_done_o           completed handshakes
//   aw/ar_len_o, aw/ar_size_o      attributes of a completed AW/AR, else 0
//   num_bytes_written_o            set strobes of an accepted W beat, else 0
//   dma_busy_o                     bursts outstanding or address/data pending
//   proto_err_o                    sticky outstanding-counter under/overflow
// All outputs are flops: one cycle from the observed inputs.
module snitch_dma_event_monitor #(
   parameter int unsigned DataWidth      = 512,
   parameter int unsigned MaxOutstanding = 16,
   localparam int unsigned StrbWidth     = DataWidth / 8,
   localparam int unsigned BytesWidth    = $clog2(StrbWidth + 1),
   localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  aw_valid_i,
   input  logic                  aw_ready_i,
   input  logic [7:0]            aw_len_i,
   input  logic [2:0]            aw_size_i,
   input  logic                  ar_valid_i,
   input  logic                  ar_ready_i,
   input  logic [7:0]            ar_len_i,
   input  logic [2:0]            ar_size_i,
   input  logic                  w_valid_i,
   input  logic                  w_ready_i,
   input  logic [StrbWidth-1:0]  w_strb_i,
   input  logic                  r_valid_i,
   input  logic                  r_ready_i,
   input  logic                  r_last_i,
   input  logic                  b_valid_i,
   input  logic                  b_ready_i,
   input  logic                  buf_w_valid_i,
   input  logic                  buf_w_ready_i,
   input  logic                  buf_r_valid_i,
   input  logic                  buf_r_ready_i,
   output logic                  aw_stall_o,
   output logic                  ar_stall_o,
   output logic                  r_stall_o,
   output logic                  w_stall_o,
   output logic                  buf_w_stall_o,
   output logic                  buf_r_stall_o,
   output logic                  aw_done_o,
   output logic                  ar_done_o,
   output logic                  r_done_o,
   output logic                  w_done_o,
   output logic                  b_done_o,
   output logic [7:0]            aw_len_o,
   output logic [7:0]            ar_len_o,
   output logic [2:0]            aw_size_o,
   output logic [2:0]            ar_size_o,
   output logic [BytesWidth-1:0] num_bytes_written_o,
   output logic                  dma_busy_o,
   output logic                  proto_err_o
);

   typedef struct packed {
      logic [CntWidth-1:0] cnt;
      logic                err;
   } cnt_upd_t;

   function automatic logic [BytesWidth-1:0] popcount(input logic [StrbWidth-1:0] s);
      logic [BytesWidth-1:0] c;
      c = '0;
      for (int i = 0; i < int'(StrbWidth); i++) begin
         c = c + BytesWidth'(s[i]);
      end
      return c;
   endfunction

   // Saturating outstanding-burst counter; a simultaneous inc and dec cancel.
   // Any attempt to step past either bound holds the value and flags an error.
   function automatic cnt_upd_t sat_update(input logic [CntWidth-1:0] cnt,
                                           input logic inc, input logic dec);
      cnt_upd_t r;
      r.cnt = cnt;
      r.err = 1'b0;
      if (inc && !dec) begin
         if (cnt == CntWidth'(MaxOutstanding)) r.err = 1'b1;
         else                                  r.cnt = cnt + CntWidth'(1);
      end else if (dec && !inc) begin
         if (cnt == '0) r.err = 1'b1;
         else           r.cnt = cnt - CntWidth'(1);
      end
      return r;
   endfunction

   logic [5:0]            stall_d, stall_q;  // {aw, ar, r, w, buf_w, buf_r}
   logic [4:0]            done_d, done_q;    // {aw, ar, r, w, b}
   logic [7:0]            aw_len_d, aw_len_q, ar_len_d, ar_len_q;
   logic [2:0]            aw_size_d, aw_size_q, ar_size_d, ar_size_q;
   logic [BytesWidth-1:0] nbytes_d, nbytes_q;
   logic [CntWidth-1:0]   wr_outst_d, wr_outst_q, rd_outst_d, rd_outst_q;
   logic                  busy_d, busy_q, proto_err_d, proto_err_q;
   cnt_upd_t              wr_upd, rd_upd;

   always_comb begin
      stall_d = {aw_valid_i & ~aw_ready_i, ar_valid_i & ~ar_ready_i,
                 r_valid_i & ~r_ready_i, w_valid_i & ~w_ready_i,
                 buf_w_valid_i & ~buf_w_ready_i, buf_r_valid_i & ~buf_r_ready_i};
      done_d  = {aw_valid_i & aw_ready_i, ar_valid_i & ar_ready_i,
                 r_valid_i & r_ready_i, w_valid_i & w_ready_i, b_valid_i & b_ready_i};

      aw_len_d  = done_d[4] ? aw_len_i  : 8'd0;
      aw_size_d = done_d[4] ? aw_size_i : 3'd0;
      ar_len_d  = done_d[3] ? ar_len_i  : 8'd0;
      ar_size_d = done_d[3] ? ar_size_i : 3'd0;
      nbytes_d  = done_d[1] ? popcount(w_strb_i) : '0;

      // A write burst retires on its B response, a read burst on its last R beat.
      wr_upd     = sat_update(wr_outst_q, done_d[4], done_d[0]);
      rd_upd     = sat_update(rd_outst_q, done_d[3], done_d[2] & r_last_i);
      wr_outst_d = wr_upd.cnt;
      rd_outst_d = rd_upd.cnt;

      proto_err_d = proto_err_q | wr_upd.err | rd_upd.err;
      // Busy looks at the post-update counters so it falls the cycle after the
      // final B / last R when nothing else is pending.
      busy_d = (wr_outst_d != '0) | (rd_outst_d != '0) | aw_valid_i | ar_valid_i | w_valid_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_q     <= '0;
         done_q      <= '0;
         aw_len_q    <= '0;
         aw_size_q   <= '0;
         ar_len_q    <= '0;
         ar_size_q   <= '0;
         nbytes_q    <= '0;
         wr_outst_q  <= '0;
         rd_outst_q  <= '0;
         busy_q      <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         stall_q     <= stall_d;
         done_q      <= done_d;
         aw_len_q    <= aw_len_d;
         aw_size_q   <= aw_size_d;
         ar_len_q    <= ar_len_d;
         ar_size_q   <= ar_size_d;
         nbytes_q    <= nbytes_d;
         wr_outst_q  <= wr_outst_d;
         rd_outst_q  <= rd_outst_d;
         busy_q      <= busy_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign {aw_stall_o, ar_stall_o, r_stall_o, w_stall_o, buf_w_stall_o, buf_r_stall_o} = stall_q;
   assign {aw_done_o, ar_done_o, r_done_o, w_done_o, b_done_o} = done_q;
   assign aw_len_o            = aw_len_q;
   assign aw_size_o           = aw_size_q;
   assign ar_len_o            = ar_len_q;
   assign ar_size_o           = ar_size_q;
   assign num_bytes_written_o = nbytes_q;
   assign dma_busy_o          = busy_q;
   assign proto_err_o         = proto_err_q;

endmodule
